// File: rtl/ysyx_22050710_trap_ctrl_pkg.sv
// Shared constants for machine-mode trap sequencing: CSR addresses, cause codes,
// mstatus field positions and the trap controller state encoding.
package ysyx_22050710_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [63:0] CAUSE_ECALL_M   = 64'd11;
    localparam logic [63:0] CAUSE_IRQ_TIMER = 64'h8000_0000_0000_0007;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        StIdle,
        StWEpc,
        StWCause,
        StWStat,
        StMStat,
        StRedir
    } trap_state_e;

endpackage

// File: rtl/ysyx_22050710_mstatus_upd.sv
// Next-mstatus computation for trap entry (stack MIE into MPIE) and mret (pop MPIE into MIE).
module ysyx_22050710_mstatus_upd
    import ysyx_22050710_trap_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [1:0]  MPP_VALUE  = 2'b11
) (
    input  logic [DATA_WIDTH-1:0] i_mstatus,
    input  logic                  i_is_mret,
    output logic [DATA_WIDTH-1:0] o_mstatus
);

    always_comb begin
        o_mstatus = i_mstatus;
        if (i_is_mret) begin
            o_mstatus[MSTATUS_MIE]  = i_mstatus[MSTATUS_MPIE];
            o_mstatus[MSTATUS_MPIE] = 1'b1;
        end else begin
            o_mstatus[MSTATUS_MPIE] = i_mstatus[MSTATUS_MIE];
            o_mstatus[MSTATUS_MIE]  = 1'b0;
        end
        o_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_VALUE;
    end

endmodule

// File: rtl/ysyx_22050710_trap_ctrl.sv
// Machine-mode trap entry/return sequencer; owns the CSR write port while a sequence runs
// and passes CSR-instruction writes through when idle.
module ysyx_22050710_trap_ctrl
    import ysyx_22050710_trap_ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH  = 12,
    parameter int unsigned          DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] MSTATUS_RST = 64'ha00001800
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic                  i_ecall,
    input  logic                  i_mret,
    input  logic                  i_irq_timer,
    input  logic                  i_inst_wen,
    input  logic [ADDR_WIDTH-1:0] i_inst_waddr,
    input  logic [DATA_WIDTH-1:0] i_inst_wdata,
    input  logic [DATA_WIDTH-1:0] i_mstatus,
    input  logic [DATA_WIDTH-1:0] i_mtvec,
    input  logic [DATA_WIDTH-1:0] i_mepc,
    output logic                  o_csr_wen,
    output logic [ADDR_WIDTH-1:0] o_csr_waddr,
    output logic [DATA_WIDTH-1:0] o_csr_wdata,
    output logic                  o_busy,
    output logic                  o_redirect,
    output logic [DATA_WIDTH-1:0] o_redirect_pc
);

    // Machine-mode MPP encoding, taken from the CSR file's reset value.
    localparam logic [1:0] MPP_M = MSTATUS_RST[MSTATUS_MPP_HI:MSTATUS_MPP_LO];

    trap_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] epc_q;
    logic [DATA_WIDTH-1:0] cause_q;
    logic                  is_mret_q;

    logic                  irq_take;
    logic                  ecall_take;
    logic                  mret_take;
    logic                  trap_take;
    logic                  event_accept;
    logic [DATA_WIDTH-1:0] mstatus_nxt;

    logic                  unused_mtvec_mode;
    assign unused_mtvec_mode = ^i_mtvec[1:0];

    // Priority irq > ecall > mret; ecall together with mret resolves to ecall.
    assign irq_take     = i_valid & i_irq_timer & i_mstatus[MSTATUS_MIE];
    assign ecall_take   = i_valid & i_ecall;
    assign mret_take    = i_valid & i_mret & ~i_ecall & ~irq_take;
    assign trap_take    = irq_take | ecall_take;
    assign event_accept = (state_q == StIdle) & (trap_take | mret_take);

    ysyx_22050710_mstatus_upd #(
        .DATA_WIDTH (DATA_WIDTH),
        .MPP_VALUE  (MPP_M)
    ) u_mstatus_upd (
        .i_mstatus (i_mstatus),
        .i_is_mret (state_q == StMStat),
        .o_mstatus (mstatus_nxt)
    );

    always_comb begin
        state_d       = state_q;
        o_csr_wen     = 1'b0;
        o_csr_waddr   = '0;
        o_csr_wdata   = '0;
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        o_busy        = (state_q != StIdle) | event_accept;

        unique case (state_q)
            StIdle: begin
                if (trap_take) begin
                    state_d = StWEpc;
                end else if (mret_take) begin
                    state_d = StMStat;
                end else begin
                    o_csr_wen   = i_inst_wen;
                    o_csr_waddr = i_inst_waddr;
                    o_csr_wdata = i_inst_wdata;
                end
            end
            StWEpc: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = ADDR_WIDTH'(CSR_MEPC);
                o_csr_wdata = {epc_q[DATA_WIDTH-1:2], 2'b00};
                state_d     = StWCause;
            end
            StWCause: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = ADDR_WIDTH'(CSR_MCAUSE);
                o_csr_wdata = cause_q;
                state_d     = StWStat;
            end
            StWStat, StMStat: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = ADDR_WIDTH'(CSR_MSTATUS);
                o_csr_wdata = mstatus_nxt;
                state_d     = StRedir;
            end
            StRedir: begin
                o_redirect    = 1'b1;
                // mepc is read here, after every write of the sequence has landed.
                o_redirect_pc = is_mret_q ? i_mepc : {i_mtvec[DATA_WIDTH-1:2], 2'b00};
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (i_rst) begin
            o_csr_wen     = 1'b0;
            o_csr_waddr   = '0;
            o_csr_wdata   = '0;
            o_busy        = 1'b0;
            o_redirect    = 1'b0;
            o_redirect_pc = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            epc_q     <= '0;
            cause_q   <= '0;
            is_mret_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (event_accept) begin
                epc_q     <= i_pc;
                is_mret_q <= ~trap_take;
                if (trap_take) begin
                    cause_q <= irq_take ? DATA_WIDTH'(CAUSE_IRQ_TIMER)
                                        : DATA_WIDTH'(CAUSE_ECALL_M);
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_trap_ctrl.sv
// Directed bench for the trap controller; a tiny CSR file closes the loop on the write port.
module tb_ysyx_22050710_trap_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [63:0] i_pc;
    logic        i_ecall;
    logic        i_mret;
    logic        i_irq_timer;
    logic        i_inst_wen;
    logic [11:0] i_inst_waddr;
    logic [63:0] i_inst_wdata;
    logic        o_csr_wen;
    logic [11:0] o_csr_waddr;
    logic [63:0] o_csr_wdata;
    logic        o_busy;
    logic        o_redirect;
    logic [63:0] o_redirect_pc;

    logic [63:0] csr_mstatus = 64'ha00001800;
    logic [63:0] csr_mtvec   = 64'h8000_0200;
    logic [63:0] csr_mepc    = 64'h0;
    logic [63:0] csr_mcause  = 64'h0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 i_clk = ~i_clk;

    ysyx_22050710_trap_ctrl dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_pc          (i_pc),
        .i_ecall       (i_ecall),
        .i_mret        (i_mret),
        .i_irq_timer   (i_irq_timer),
        .i_inst_wen    (i_inst_wen),
        .i_inst_waddr  (i_inst_waddr),
        .i_inst_wdata  (i_inst_wdata),
        .i_mstatus     (csr_mstatus),
        .i_mtvec       (csr_mtvec),
        .i_mepc        (csr_mepc),
        .o_csr_wen     (o_csr_wen),
        .o_csr_waddr   (o_csr_waddr),
        .o_csr_wdata   (o_csr_wdata),
        .o_busy        (o_busy),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc)
    );

    always_ff @(posedge i_clk) begin
        if (o_csr_wen) begin
            case (o_csr_waddr)
                12'h300: csr_mstatus <= o_csr_wdata;
                12'h305: csr_mtvec   <= o_csr_wdata;
                12'h341: csr_mepc    <= o_csr_wdata;
                12'h342: csr_mcause  <= o_csr_wdata;
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_pc = '0; i_ecall = 1'b0; i_mret = 1'b0;
        i_irq_timer = 1'b0; i_inst_wen = 1'b0; i_inst_waddr = '0; i_inst_wdata = '0;

        tick(); tick();
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_wen", 64'(o_csr_wen), 64'd0);
        check("rst_redirect", 64'(o_redirect), 64'd0);
        i_rst = 1'b0;

        // ecall at 0x8000_0104
        tick();
        i_valid = 1'b1; i_ecall = 1'b1; i_pc = 64'h8000_0104; #1;
        check("ecall_accept_busy", 64'(o_busy), 64'd1);
        check("ecall_accept_wen", 64'(o_csr_wen), 64'd0);
        tick();
        i_valid = 1'b0; i_ecall = 1'b0; #1;
        check("ecall_epc_addr", 64'(o_csr_waddr), 64'h341);
        check("ecall_epc_data", o_csr_wdata, 64'h8000_0104);
        tick();
        check("ecall_cause_addr", 64'(o_csr_waddr), 64'h342);
        check("ecall_cause_data", o_csr_wdata, 64'd11);
        tick();
        check("ecall_stat_addr", 64'(o_csr_waddr), 64'h300);
        check("ecall_stat_data", o_csr_wdata, 64'ha00001800);
        check("ecall_stat_busy", 64'(o_busy), 64'd1);
        tick();
        check("ecall_redir", 64'(o_redirect), 64'd1);
        check("ecall_redir_pc", o_redirect_pc, 64'h8000_0200);
        check("ecall_redir_wen", 64'(o_csr_wen), 64'd0);
        tick();
        check("ecall_done_busy", 64'(o_busy), 64'd0);
        check("ecall_done_redir", 64'(o_redirect), 64'd0);

        // Preload mstatus (MPIE=1, MIE=0) and mepc through the pass-through path
        i_inst_wen = 1'b1; i_inst_waddr = 12'h300; i_inst_wdata = 64'ha00001880; #1;
        check("pass_mstatus_data", o_csr_wdata, 64'ha00001880);
        tick();
        i_inst_waddr = 12'h341; i_inst_wdata = 64'h8000_0108;
        tick();
        i_inst_wen = 1'b0;
        i_valid = 1'b1; i_mret = 1'b1; #1;
        check("mret_accept_busy", 64'(o_busy), 64'd1);
        tick();
        i_valid = 1'b0; i_mret = 1'b0; #1;
        check("mret_stat_addr", 64'(o_csr_waddr), 64'h300);
        check("mret_stat_data", o_csr_wdata, 64'ha00001888);
        tick();
        check("mret_redir", 64'(o_redirect), 64'd1);
        check("mret_redir_pc", o_redirect_pc, 64'h8000_0108);
        tick();

        // irq with MIE=1 and a same-cycle MTVEC write that must be dropped
        i_valid = 1'b1; i_irq_timer = 1'b1; i_pc = 64'h8000_0300;
        i_inst_wen = 1'b1; i_inst_waddr = 12'h305; i_inst_wdata = 64'h1234; #1;
        check("irq_accept_wen", 64'(o_csr_wen), 64'd0);
        check("irq_accept_busy", 64'(o_busy), 64'd1);
        tick();
        i_valid = 1'b0; i_inst_wen = 1'b0; #1;
        check("irq_epc_data", o_csr_wdata, 64'h8000_0300);
        tick();
        check("irq_cause_data", o_csr_wdata, 64'h8000_0000_0000_0007);
        tick();
        check("irq_stat_data", o_csr_wdata, 64'ha00001880);
        tick();
        check("irq_redir_pc", o_redirect_pc, 64'h8000_0200);
        tick();
        i_irq_timer = 1'b0;

        // irq with MIE=0: no sequence, instruction write passes through
        i_valid = 1'b1; i_irq_timer = 1'b1;
        i_inst_wen = 1'b1; i_inst_waddr = 12'h305; i_inst_wdata = 64'h8000_0400; #1;
        check("irqoff_busy", 64'(o_busy), 64'd0);
        check("irqoff_wen", 64'(o_csr_wen), 64'd1);
        check("irqoff_addr", 64'(o_csr_waddr), 64'h305);
        check("irqoff_data", o_csr_wdata, 64'h8000_0400);
        tick();
        i_valid = 1'b0; i_irq_timer = 1'b0; i_inst_wen = 1'b0; #1;
        check("irqoff_next_busy", 64'(o_busy), 64'd0);

        // Reset during W_CAUSE
        i_valid = 1'b1; i_ecall = 1'b1; i_pc = 64'h8000_0500;
        tick();
        i_valid = 1'b0; i_ecall = 1'b0; #1;
        check("rstmid_epc_data", o_csr_wdata, 64'h8000_0500);
        tick();
        i_rst = 1'b1; #1;
        check("rstmid_cause_redir", 64'(o_redirect), 64'd0);
        tick();
        i_rst = 1'b0; #1;
        check("rstmid_idle_busy", 64'(o_busy), 64'd0);
        check("rstmid_idle_redir", 64'(o_redirect), 64'd0);
        check("rstmid_mepc_kept", csr_mepc, 64'h8000_0500);
        tick();
        check("rstmid_later_redir", 64'(o_redirect), 64'd0);
        tick();
        check("rstmid_later2_redir", 64'(o_redirect), 64'd0);

        // Back-to-back ecall then mret, starting with MIE=1
        i_inst_wen = 1'b1; i_inst_waddr = 12'h300; i_inst_wdata = 64'ha00001888;
        tick();
        i_inst_wen = 1'b0;
        i_valid = 1'b1; i_ecall = 1'b1; i_pc = 64'h8000_0600;
        tick();
        i_ecall = 1'b0; i_mret = 1'b1; #1;
        check("b2b_hold_busy", 64'(o_busy), 64'd1);
        tick(); tick(); tick();
        check("b2b_redir_pc", o_redirect_pc, 64'h8000_0400);
        check("b2b_redir_busy", 64'(o_busy), 64'd1);
        tick();
        check("b2b_mret_accept", 64'(o_busy), 64'd1);
        check("b2b_mret_accept_wen", 64'(o_csr_wen), 64'd0);
        tick();
        i_valid = 1'b0; i_mret = 1'b0; #1;
        check("b2b_mret_stat_data", o_csr_wdata, 64'ha00001888);
        tick();
        check("b2b_mret_redir_pc", o_redirect_pc, 64'h8000_0600);
        tick();
        check("b2b_final_mstatus", csr_mstatus, 64'ha00001888);

        // ecall with mret in the same cycle: ecall wins, mepc low bits cleared
        i_valid = 1'b1; i_ecall = 1'b1; i_mret = 1'b1; i_pc = 64'h8000_0703;
        tick();
        i_valid = 1'b0; i_ecall = 1'b0; i_mret = 1'b0; #1;
        check("both_epc_addr", 64'(o_csr_waddr), 64'h341);
        check("both_epc_data", o_csr_wdata, 64'h8000_0700);
        tick(); tick(); tick();
        check("both_redir_pc", o_redirect_pc, 64'h8000_0400);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
